shift_reg_sipo_rx: RTL and testbench
====================================

# shift_reg_sipo_rx

Serial-in parallel-out receive register for the SPI controller, the receive counterpart of the transmit PISO shifter. Samples one serial bit per `ena` strobe, assembles WIDTH-bit words (MSB first by default, matching the left-shifting transmitter), and hands complete words to the parallel side through a one-word holding register. The holding register has a valid/read handshake and a sticky overrun flag. Sits between the SPI bit-timing logic, which supplies `ena` on the sample edge, and the controller's parallel data path.

## Interface
- WIDTH, 8, word length in bits (2..32)
- MSB_FIRST, 1, 1 = first received bit lands in DatOut[WIDTH-1]; 0 = first bit lands in DatOut[0]
- clk  in  1  system clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- ena  in  1  bit strobe; DatIn sampled on the rising edge where ena=1
- clr  in  1  synchronous frame abort: clears partial word and overrun
- DatIn  in  1  serial data bit
- rd  in  1  parallel-side read; consumes the held word when full=1
- DatOut  out  WIDTH  held word, stable while full=1
- full  out  1  holding register contains an unread word
- valid  out  1  one-cycle pulse when a new word enters the holding register
- busy  out  1  partial word in progress (bit count nonzero)
- overrun  out  1  sticky: a completed word was dropped because the holding register was full

## Operation
- Reset values: DatOut=0, full=0, valid=0, busy=0, overrun=0. Shift register and bit count are 0. State is IDLE.
- States:
  - IDLE (count=0)
  - SHIFT (0<count<WIDTH)
- Transitions:
  - IDLE→SHIFT on ena.
  - SHIFT→SHIFT on ena while count+1<WIDTH.
  - SHIFT→IDLE on the ena that completes the word, or on clr.
- Shifting:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], DatIn}.
  - MSB_FIRST=0: sr <= {DatIn, sr[WIDTH-1:1]}.
- Completion: on the WIDTH-th ena, the assembled word (including the bit sampled that edge) goes to the holding register.
  - Load condition: full=0, or rd=1 in the same cycle.
  - On load: DatOut takes the word, full=1, valid=1 for one cycle, count=0.
  - No load (full=1 and rd=0): the word is discarded, DatOut is unchanged, overrun becomes 1, count=0.
- rd with full=1 and no completion: full <= 0. DatOut keeps its value.
- rd with full=0: ignored.
- Simultaneous rd and completion with full=1: old word is consumed, new word is loaded, full stays 1, valid pulses, no overrun.
- clr has priority over ena:
  - Clears sr, count and overrun.
  - Does not affect DatOut or full.
  - ena in the same cycle is ignored.
- Overrun clears only on clr or rst.
- Async rst mid-word: all state returns to reset values immediately. The partial word is lost.
- Count width is $clog2(WIDTH+1). The count never exceeds WIDTH-1 at a clock edge.

## Timing
- One bit per ena cycle, back-to-back ena permitted.
- Word latency: DatOut, full and valid update on the same rising edge that samples the last bit, and are visible in the following cycle.
- valid is high for exactly one cycle per loaded word.
- busy is registered and equals (count != 0).
- rd takes effect on the edge where it is sampled. full falls in the next cycle.
- Maximum sustained rate: one word per WIDTH cycles with no overrun, provided rd is asserted within WIDTH cycles of valid.

## Structure
- Shared package spi_pkg holds:
  - rx_state_t enum (IDLE, SHIFT).
  - Default word width constant SPI_WIDTH=8, shared with the transmit shifter.
- One sub-module, sipo_shift_core: shift register plus bit counter, emitting word and done.
- The top level holds the holding register, handshake and overrun logic.

## Test plan
- Reset, then 8 ena strobes with DatIn=1,0,1,0,0,1,0,1 (MSB_FIRST=1) -> after the 8th edge: DatOut=8'hA5, full=1, valid=1 for exactly one cycle, busy=0.
- MSB_FIRST=0, same bit sequence -> DatOut=8'hA5 reversed = 8'hA5? No: the sequence is chosen as 1,1,0,0,0,0,0,0 -> DatOut=8'h03.
- Leave 8'h3C unread and shift in a second word 8'hFF -> overrun=1, DatOut stays 8'h3C. Then clr -> overrun=0, full=1, DatOut=8'h3C.
- Word 8'h11 held; assert rd on the same edge as the 8th bit of 8'h22 -> DatOut=8'h22, full=1, valid pulse, overrun=0.
- 4 bits shifted, then clr, then 8 bits of 8'h5A -> DatOut=8'h5A, with no contamination from the aborted partial bits.
- Assert async rst after the 5th bit, between clock edges -> all outputs 0 immediately. A subsequent full 8'hC3 word is received correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by the transmit and receive shifters.
package spi_pkg;

    // Default word width, shared with the transmit PISO shifter.
    localparam int unsigned SPI_WIDTH = 8;

    // Receive shifter state: IDLE while no bits are held, SHIFT mid-word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/sipo_shift_core.sv
// Serial-in shift register plus bit counter. Emits the assembled word
// (including the bit sampled this cycle) together with a done strobe on the
// ena that completes a word.
module sipo_shift_core
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH     = SPI_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic             din,
    output logic [WIDTH-1:0] word,
    output logic             done,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    count;
    rx_state_t        state;

    // Next shift value and word-complete detection; clr masks a completion.
    always_comb begin
        sr_next = MSB_FIRST ? {sr[WIDTH-2:0], din} : {din, sr[WIDTH-1:1]};
        word    = sr_next;
        done    = ena && !clr && (count == CW'(WIDTH - 1));
    end

    // Shift register, bit counter and state; clr wins over ena.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            count <= '0;
            state <= IDLE;
        end else if (clr) begin
            sr    <= '0;
            count <= '0;
            state <= IDLE;
        end else if (ena) begin
            sr <= sr_next;
            if (done) begin
                count <= '0;
                state <= IDLE;
            end else begin
                count <= count + CW'(1);
                state <= SHIFT;
            end
        end
    end

    // SHIFT is held exactly while the count is nonzero.
    assign busy = (state == SHIFT);

endmodule

// File: rtl/shift_reg_sipo_rx.sv
// SPI receive SIPO: assembles serial bits into words and hands them to the
// parallel side through a one-word holding register with valid/read
// handshake and a sticky overrun flag.
module shift_reg_sipo_rx
    import spi_pkg::*;
#(
    parameter int unsigned WIDTH     = SPI_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             clr,
    input  logic             DatIn,
    input  logic             rd,
    output logic [WIDTH-1:0] DatOut,
    output logic             full,
    output logic             valid,
    output logic             busy,
    output logic             overrun
);

    logic [WIDTH-1:0] word;
    logic             done;
    logic             load;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_core (
        .clk  (clk),
        .rst  (rst),
        .ena  (ena),
        .clr  (clr),
        .din  (DatIn),
        .word (word),
        .done (done),
        .busy (busy)
    );

    // A completed word is accepted if the slot is empty or being read now.
    always_comb begin
        load = done && (!full || rd);
    end

    // Holding register and handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            DatOut <= '0;
            full   <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= load;
            if (load) begin
                DatOut <= word;
                full   <= 1'b1;
            end else if (rd && full) begin
                full <= 1'b0;
            end
        end
    end

    // Sticky overrun: set when a finished word is dropped, cleared by clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (clr) begin
            overrun <= 1'b0;
        end else if (done && !load) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_shift_reg_sipo_rx.sv
// Self-checking bench for shift_reg_sipo_rx: directed scenarios followed by
// random traffic, both checked against a queue-based reference model. Two
// instances (MSB-first and LSB-first) see identical stimulus.
module tb_shift_reg_sipo_rx;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ena = 1'b0;
    logic         clr = 1'b0;
    logic         din = 1'b0;
    logic         rd  = 1'b0;
    logic [W-1:0] dat_m, dat_l;
    logic         full_m, full_l, valid_m, valid_l, busy_m, busy_l, ovr_m, ovr_l;

    int compared = 0;
    int mism     = 0;

    // Reference model state
    bit           bq[$];
    logic [W-1:0] h_m, h_l;
    logic         m_full, m_valid, m_ovr;

    always #5 clk = ~clk;

    shift_reg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk (clk), .rst (rst), .ena (ena), .clr (clr), .DatIn (din), .rd (rd),
        .DatOut (dat_m), .full (full_m), .valid (valid_m), .busy (busy_m),
        .overrun (ovr_m)
    );

    shift_reg_sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk (clk), .rst (rst), .ena (ena), .clr (clr), .DatIn (din), .rd (rd),
        .DatOut (dat_l), .full (full_l), .valid (valid_l), .busy (busy_l),
        .overrun (ovr_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        h_m = '0; h_l = '0; m_full = 0; m_valid = 0; m_ovr = 0;
    endtask

    // Apply one clock's worth of inputs to the model, from its pre-edge state.
    task automatic model_step(input logic e, input logic c, input logic d, input logic r);
        logic [W-1:0] wm, wl;
        m_valid = 0;
        if (c) begin
            bq.delete();
            m_ovr = 0;
            if (r && m_full) m_full = 0;
        end else begin
            if (e) bq.push_back(d);
            if (bq.size() == W) begin
                wm = '0; wl = '0;
                for (int i = 0; i < W; i++) begin
                    wm[W-1-i] = bq[i];
                    wl[i]     = bq[i];
                end
                bq.delete();
                if (!m_full || r) begin
                    h_m = wm; h_l = wl; m_full = 1; m_valid = 1;
                end else begin
                    m_ovr = 1;
                end
            end else if (r && m_full) begin
                m_full = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("dat_msb",   dat_m,   h_m);
        chk("dat_lsb",   dat_l,   h_l);
        chk("full_msb",  full_m,  m_full);
        chk("full_lsb",  full_l,  m_full);
        chk("valid_msb", valid_m, m_valid);
        chk("valid_lsb", valid_l, m_valid);
        chk("busy_msb",  busy_m,  bq.size() != 0);
        chk("busy_lsb",  busy_l,  bq.size() != 0);
        chk("ovr_msb",   ovr_m,   m_ovr);
        chk("ovr_lsb",   ovr_l,   m_ovr);
    endtask

    // Drive one cycle of inputs, update the model, sample 1ns after the edge.
    task automatic step(input logic e, input logic c, input logic d, input logic r);
        ena = e; clr = c; din = d; rd = r;
        model_step(e, c, d, r);
        @(posedge clk);
        #1;
        check_all();
        ena = 0; clr = 0; din = 0; rd = 0;
    endtask

    // Shift a byte in MSB-first bit order; optionally assert rd on the last bit.
    task automatic send_bits(input logic [W-1:0] b, input logic rd_last);
        for (int i = W - 1; i >= 0; i--) begin
            step(1'b1, 1'b0, b[i], (i == 0) ? rd_last : 1'b0);
        end
    endtask

    initial begin
        logic e, c, r;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dat",   dat_m,   '0);
        chk("rst_full",  full_m,  1'b0);
        chk("rst_valid", valid_m, 1'b0);
        chk("rst_busy",  busy_m,  1'b0);
        chk("rst_ovr",   ovr_m,   1'b0);
        rst = 0;

        // Word A5 MSB-first
        send_bits(8'hA5, 1'b0);
        chk("t1_dat",   dat_m,   8'hA5);
        chk("t1_full",  full_m,  1'b1);
        chk("t1_valid", valid_m, 1'b1);
        chk("t1_busy",  busy_m,  1'b0);
        step(0, 0, 0, 0);
        chk("t1_valid_once", valid_m, 1'b0);

        // Bits 1,1,0,0,0,0,0,0 on the LSB-first instance give 03
        step(0, 0, 0, 1);
        send_bits(8'hC0, 1'b0);
        chk("t2_dat_lsb", dat_l, 8'h03);
        chk("t2_dat_msb", dat_m, 8'hC0);

        // Overrun: 3C left unread, FF dropped, then clr
        step(0, 0, 0, 1);
        send_bits(8'h3C, 1'b0);
        send_bits(8'hFF, 1'b0);
        chk("t3_ovr",  ovr_m, 1'b1);
        chk("t3_dat",  dat_m, 8'h3C);
        step(0, 1, 0, 0);
        chk("t3_clr_ovr",  ovr_m,  1'b0);
        chk("t3_clr_full", full_m, 1'b1);
        chk("t3_clr_dat",  dat_m,  8'h3C);

        // Read coincident with completion while full
        step(0, 0, 0, 1);
        send_bits(8'h11, 1'b0);
        send_bits(8'h22, 1'b1);
        chk("t4_dat",   dat_m,   8'h22);
        chk("t4_full",  full_m,  1'b1);
        chk("t4_valid", valid_m, 1'b1);
        chk("t4_ovr",   ovr_m,   1'b0);

        // Partial word aborted by clr leaves no residue
        step(0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0);
        chk("t5_busy", busy_m, 1'b1);
        step(1, 1, 1, 0);
        chk("t5_busy_clr", busy_m, 1'b0);
        send_bits(8'h5A, 1'b0);
        chk("t5_dat", dat_m, 8'h5A);

        // Async reset between edges after 5 bits
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, i[0], 0);
        #3;
        rst = 1;
        #1;
        model_reset();
        chk("t6_dat",   dat_m,   '0);
        chk("t6_full",  full_m,  1'b0);
        chk("t6_valid", valid_m, 1'b0);
        chk("t6_busy",  busy_m,  1'b0);
        chk("t6_ovr",   ovr_m,   1'b0);
        #1;
        rst = 0;
        send_bits(8'hC3, 1'b0);
        chk("t6_dat_after", dat_m, 8'hC3);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            e = ($urandom_range(0, 9) < 7);
            c = ($urandom_range(0, 99) < 3);
            r = ($urandom_range(0, 9) < 2);
            step(e, c, 1'($urandom), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
